reservation_station: RTL and testbench

- Out-of-order issue buffer for integer and branch ops in the Tomasulo core.
- Sits between decoder/issue and the combinational ALU, which it drives directly.
- Holds up to RS_SIZE decoded ops and snoops the ALU and LSB result buses to resolve operand tags.
- Each cycle it dispatches at most one fully-ready op to the ALU through a registered output stage.

---
 rtl/reservation_station.sv | 177 +++++++++++++++++
 tb/tb_reservation_station.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station for integer/branch ops: buffers decoded ops, snoops the
// ALU and LSB result buses for operand tags, and dispatches one ready op per cycle.
module reservation_station #(
  parameter int          RS_SIZE  = 16,
  parameter int          ROB_W    = 4,
  parameter logic [5:0]  NOP_CODE = 6'd0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rollback_in,

  input  logic             issue_valid,
  input  logic [5:0]       issue_inst_name,
  input  logic [31:0]      issue_V1,
  input  logic [31:0]      issue_V2,
  input  logic             issue_Q1_busy,
  input  logic             issue_Q2_busy,
  input  logic [ROB_W-1:0] issue_Q1,
  input  logic [ROB_W-1:0] issue_Q2,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_pc,
  input  logic [ROB_W-1:0] issue_rob_id,
  output logic             full,

  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob_id,
  input  logic [31:0]      alu_cdb_result,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob_id,
  input  logic [31:0]      lsb_cdb_result,

  output logic [5:0]       exe_inst_name,
  output logic [31:0]      exe_V1,
  output logic [31:0]      exe_V2,
  output logic [31:0]      exe_imm,
  output logic [31:0]      exe_pc,
  output logic [ROB_W-1:0] exe_rob_id
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic [5:0]       inst_name;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic             q1_busy;
    logic             q2_busy;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [ROB_W-1:0] rob_id;
  } entry_t;

  logic [RS_SIZE-1:0] busy;
  entry_t             ent [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               ready_found;
  logic [IDX_W-1:0]   ready_idx;
  entry_t             new_ent;

  assign full = &busy;

  // Descending scans so the lowest index is the one left standing.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy[i] & ~ent[i].q1_busy & ~ent[i].q2_busy;
    end
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready[i]) begin
        ready_found = 1'b1;
        ready_idx   = IDX_W'(i);
      end
    end
  end

  // Incoming op with same-cycle CDB bypass; ALU data wins over LSB on a tie.
  always_comb begin
    new_ent.inst_name = issue_inst_name;
    new_ent.v1        = issue_V1;
    new_ent.v2        = issue_V2;
    new_ent.q1_busy   = issue_Q1_busy;
    new_ent.q2_busy   = issue_Q2_busy;
    new_ent.q1        = issue_Q1;
    new_ent.q2        = issue_Q2;
    new_ent.imm       = issue_imm;
    new_ent.pc        = issue_pc;
    new_ent.rob_id    = issue_rob_id;
    if (issue_Q1_busy) begin
      if (alu_cdb_valid && alu_cdb_rob_id == issue_Q1) begin
        new_ent.v1      = alu_cdb_result;
        new_ent.q1_busy = 1'b0;
      end else if (lsb_cdb_valid && lsb_cdb_rob_id == issue_Q1) begin
        new_ent.v1      = lsb_cdb_result;
        new_ent.q1_busy = 1'b0;
      end
    end
    if (issue_Q2_busy) begin
      if (alu_cdb_valid && alu_cdb_rob_id == issue_Q2) begin
        new_ent.v2      = alu_cdb_result;
        new_ent.q2_busy = 1'b0;
      end else if (lsb_cdb_valid && lsb_cdb_rob_id == issue_Q2) begin
        new_ent.v2      = lsb_cdb_result;
        new_ent.q2_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || rollback_in) begin
      busy          <= '0;
      exe_inst_name <= NOP_CODE;
      exe_V1        <= '0;
      exe_V2        <= '0;
      exe_imm       <= '0;
      exe_pc        <= '0;
      exe_rob_id    <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && ent[i].q1_busy) begin
          if (alu_cdb_valid && alu_cdb_rob_id == ent[i].q1) begin
            ent[i].v1      <= alu_cdb_result;
            ent[i].q1_busy <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob_id == ent[i].q1) begin
            ent[i].v1      <= lsb_cdb_result;
            ent[i].q1_busy <= 1'b0;
          end
        end
        if (busy[i] && ent[i].q2_busy) begin
          if (alu_cdb_valid && alu_cdb_rob_id == ent[i].q2) begin
            ent[i].v2      <= alu_cdb_result;
            ent[i].q2_busy <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob_id == ent[i].q2) begin
            ent[i].v2      <= lsb_cdb_result;
            ent[i].q2_busy <= 1'b0;
          end
        end
      end

      if (ready_found) begin
        exe_inst_name   <= ent[ready_idx].inst_name;
        exe_V1          <= ent[ready_idx].v1;
        exe_V2          <= ent[ready_idx].v2;
        exe_imm         <= ent[ready_idx].imm;
        exe_pc          <= ent[ready_idx].pc;
        exe_rob_id      <= ent[ready_idx].rob_id;
        busy[ready_idx] <= 1'b0;
      end else begin
        exe_inst_name <= NOP_CODE;
        exe_V1        <= '0;
        exe_V2        <= '0;
        exe_imm       <= '0;
        exe_pc        <= '0;
        exe_rob_id    <= '0;
      end

      // The free slot is never the dispatched one, so these writes cannot collide.
      if (issue_valid && free_found) begin
        ent[free_idx]  <= new_ent;
        busy[free_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: table of single-op vectors plus
// hand-written sequences for fill order, stall, delayed wakeup and rollback.
module tb_reservation_station;

  localparam logic [5:0] NOP = 6'd0;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        issue_valid;
  logic [5:0]  issue_inst_name;
  logic [31:0] issue_V1, issue_V2, issue_imm, issue_pc;
  logic        issue_Q1_busy, issue_Q2_busy;
  logic [3:0]  issue_Q1, issue_Q2, issue_rob_id;
  logic        full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0] alu_cdb_result, lsb_cdb_result;
  logic [5:0]  exe_inst_name;
  logic [31:0] exe_V1, exe_V2, exe_imm, exe_pc;
  logic [3:0]  exe_rob_id;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  reservation_station dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rollback_in(rollback),
    .issue_valid(issue_valid), .issue_inst_name(issue_inst_name),
    .issue_V1(issue_V1), .issue_V2(issue_V2),
    .issue_Q1_busy(issue_Q1_busy), .issue_Q2_busy(issue_Q2_busy),
    .issue_Q1(issue_Q1), .issue_Q2(issue_Q2),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_id(issue_rob_id),
    .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id),
    .alu_cdb_result(alu_cdb_result),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id),
    .lsb_cdb_result(lsb_cdb_result),
    .exe_inst_name(exe_inst_name), .exe_V1(exe_V1), .exe_V2(exe_V2),
    .exe_imm(exe_imm), .exe_pc(exe_pc), .exe_rob_id(exe_rob_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  inst;
    logic [31:0] v1, v2;
    logic        q1b, q2b;
    logic [3:0]  q1, q2;
    logic [31:0] imm, pc;
    logic [3:0]  rob;
    logic        av;
    logic [3:0]  aid;
    logic [31:0] ad;
    logic        lv;
    logic [3:0]  lid;
    logic [31:0] ld;
    logic        disp;
    logic [31:0] ev1, ev2;
  } vec_t;

  vec_t vecs [8];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rdy = 1'b1; rollback = 1'b0;
    issue_valid = 1'b0; issue_inst_name = '0;
    issue_V1 = '0; issue_V2 = '0; issue_imm = '0; issue_pc = '0;
    issue_Q1_busy = 1'b0; issue_Q2_busy = 1'b0;
    issue_Q1 = '0; issue_Q2 = '0; issue_rob_id = '0;
    alu_cdb_valid = 1'b0; alu_cdb_rob_id = '0; alu_cdb_result = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_result = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_issue(input logic [5:0] inst, input logic [31:0] v1, v2,
                             input logic q1b, q2b, input logic [3:0] q1, q2,
                             input logic [31:0] imm, pc, input logic [3:0] rob);
    issue_valid = 1'b1; issue_inst_name = inst;
    issue_V1 = v1; issue_V2 = v2;
    issue_Q1_busy = q1b; issue_Q2_busy = q2b;
    issue_Q1 = q1; issue_Q2 = q2;
    issue_imm = imm; issue_pc = pc; issue_rob_id = rob;
  endtask

  task automatic alu_bcast(input logic [3:0] id, input logic [31:0] d);
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = id; alu_cdb_result = d;
  endtask

  task automatic lsb_bcast(input logic [3:0] id, input logic [31:0] d);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = id; lsb_cdb_result = d;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_nop(input string name);
    chk({name, " inst"}, 32'(exe_inst_name), 32'(NOP));
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    vecs[0] = '{6'd1, 32'd5, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h1000, 4'd3,
                1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'd5, 32'd7};
    vecs[1] = '{6'd2, 32'd0, 32'd0, 1'b1, 1'b0, 4'd6, 4'd0, 32'd1, 32'h2000, 4'd8,
                1'b1, 4'd6, 32'h10, 1'b0, 4'd0, 32'd0, 1'b1, 32'h10, 32'd0};
    vecs[2] = '{6'd3, 32'h20, 32'd0, 1'b0, 1'b1, 4'd0, 4'd4, 32'd0, 32'h3000, 4'd5,
                1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hDEAD, 1'b1, 32'h20, 32'hDEAD};
    vecs[3] = '{6'd4, 32'd0, 32'd0, 1'b1, 1'b1, 4'd2, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 4'd6,
                1'b1, 4'd9, 32'hBB, 1'b1, 4'd2, 32'hAA, 1'b1, 32'hAA, 32'hBB};
    vecs[4] = '{6'd5, 32'd0, 32'd9, 1'b1, 1'b0, 4'd5, 4'd0, 32'd0, 32'h44, 4'd15,
                1'b1, 4'd5, 32'h111, 1'b1, 4'd5, 32'h222, 1'b1, 32'h111, 32'd9};
    vecs[5] = '{6'd6, 32'd0, 32'd0, 1'b1, 1'b0, 4'd3, 4'd0, 32'd0, 32'h48, 4'd1,
                1'b1, 4'd11, 32'h5, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 32'd0};
    vecs[6] = '{6'd7, 32'h44, 32'd1, 1'b0, 1'b0, 4'd4, 4'd0, 32'd2, 32'h4C, 4'd0,
                1'b1, 4'd4, 32'h99, 1'b0, 4'd0, 32'd0, 1'b1, 32'h44, 32'd1};
    vecs[7] = '{6'd63, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 4'd0, 4'd0,
                32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'hF,
                1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000};

    // reset state
    do_reset();
    chk("reset full", 32'(full), 32'd0);
    chk_nop("reset");
    chk("reset V1", exe_V1, 32'd0);
    chk("reset rob", 32'(exe_rob_id), 32'd0);

    // table-driven single-op vectors: issue at t, check t+2 and t+3
    for (int v = 0; v < 8; v++) begin
      do_reset();
      drive_issue(vecs[v].inst, vecs[v].v1, vecs[v].v2, vecs[v].q1b, vecs[v].q2b,
                  vecs[v].q1, vecs[v].q2, vecs[v].imm, vecs[v].pc, vecs[v].rob);
      if (vecs[v].av) alu_bcast(vecs[v].aid, vecs[v].ad);
      if (vecs[v].lv) lsb_bcast(vecs[v].lid, vecs[v].ld);
      tick();
      clear_inputs();
      chk_nop($sformatf("vec%0d t+1", v));
      tick();
      if (vecs[v].disp) begin
        chk($sformatf("vec%0d inst", v), 32'(exe_inst_name), 32'(vecs[v].inst));
        chk($sformatf("vec%0d V1", v), exe_V1, vecs[v].ev1);
        chk($sformatf("vec%0d V2", v), exe_V2, vecs[v].ev2);
        chk($sformatf("vec%0d imm", v), exe_imm, vecs[v].imm);
        chk($sformatf("vec%0d pc", v), exe_pc, vecs[v].pc);
        chk($sformatf("vec%0d rob", v), 32'(exe_rob_id), 32'(vecs[v].rob));
      end else begin
        chk_nop($sformatf("vec%0d t+2", v));
      end
      tick();
      chk_nop($sformatf("vec%0d t+3", v));
      chk($sformatf("vec%0d t+3 V1", v), exe_V1, 32'd0);
    end

    // delayed wakeup: broadcast at t+3 -> dispatch at t+5
    do_reset();
    drive_issue(6'd2, 32'd0, 32'd0, 1'b1, 1'b0, 4'd6, 4'd0, 32'd1, 32'h40, 4'd7);
    tick(); clear_inputs();
    tick(); chk_nop("late t+2");
    tick(); chk_nop("late t+3");
    alu_bcast(4'd6, 32'h10);
    tick(); clear_inputs(); chk_nop("late t+4");
    tick();
    chk("late inst", 32'(exe_inst_name), 32'd2);
    chk("late V1", exe_V1, 32'h10);
    chk("late imm", exe_imm, 32'd1);
    chk("late rob", 32'(exe_rob_id), 32'd7);
    tick(); chk_nop("late t+6");

    // dual CDB onto an already-waiting entry
    do_reset();
    drive_issue(6'd11, 32'd0, 32'd0, 1'b1, 1'b1, 4'd2, 4'd9, 32'd0, 32'h80, 4'd4);
    tick(); clear_inputs();
    lsb_bcast(4'd2, 32'hAA);
    alu_bcast(4'd9, 32'hBB);
    tick(); clear_inputs(); chk_nop("dual t+1");
    tick();
    chk("dual V1", exe_V1, 32'hAA);
    chk("dual V2", exe_V2, 32'hBB);
    chk("dual rob", 32'(exe_rob_id), 32'd4);

    // fill to 16, ignored 17th, then in-order drain after one wakeup
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_issue(6'd3, 32'd0, 32'(i * 3), 1'b1, 1'b0, 4'd1, 4'd0, 32'd0, 32'(i), 4'(i));
      exp_q.push_back(4'(i));
      tick();
      if (i == 14) chk("fill full@15", 32'(full), 32'd0);
    end
    chk("fill full@16", 32'(full), 32'd1);
    drive_issue(6'd63, 32'h999, 32'h999, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 4'hF);
    tick(); clear_inputs();
    chk("fill full after 17th", 32'(full), 32'd1);
    alu_bcast(4'd1, 32'h55);
    tick(); clear_inputs();
    chk("drain full c+1", 32'(full), 32'd1);
    chk_nop("drain c+1");
    tick();
    chk("drain full c+2", 32'(full), 32'd0);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] e;
      if (exp_q.size() == 0) begin
        chk("drain queue underflow", 32'd0, 32'd1);
        break;
      end
      e = exp_q.pop_front();
      chk($sformatf("drain%0d inst", k), 32'(exe_inst_name), 32'd3);
      chk($sformatf("drain%0d rob", k), 32'(exe_rob_id), 32'(e));
      chk($sformatf("drain%0d V1", k), exe_V1, 32'h55);
      chk($sformatf("drain%0d V2", k), exe_V2, 32'(k * 3));
      tick();
    end
    chk_nop("drain end");
    chk("drain queue empty", 32'(exp_q.size()), 32'd0);

    // stall: exe holds, no dispatch/issue/wakeup while rdy low
    do_reset();
    drive_issue(6'd7, 32'd1, 32'd2, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h100, 4'd1);
    tick();
    drive_issue(6'd8, 32'd3, 32'd4, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h104, 4'd2);
    tick();
    chk("stall A inst", 32'(exe_inst_name), 32'd7);
    drive_issue(6'd9, 32'd0, 32'd5, 1'b1, 1'b0, 4'd8, 4'd0, 32'd0, 32'h108, 4'd3);
    tick();
    chk("stall B inst", 32'(exe_inst_name), 32'd8);
    clear_inputs();
    rdy = 1'b0;
    alu_bcast(4'd8, 32'hCC);
    drive_issue(6'd10, 32'd6, 32'd6, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h10C, 4'd13);
    tick();
    chk("stall hold1 inst", 32'(exe_inst_name), 32'd8);
    chk("stall hold1 V1", exe_V1, 32'd3);
    tick();
    chk("stall hold2 rob", 32'(exe_rob_id), 32'd2);
    clear_inputs();
    tick(); chk_nop("stall lost cdb t+6");
    tick(); chk_nop("stall lost cdb t+7");
    alu_bcast(4'd8, 32'hCC);
    tick(); clear_inputs(); chk_nop("stall t+8");
    tick();
    chk("stall C inst", 32'(exe_inst_name), 32'd9);
    chk("stall C V1", exe_V1, 32'hCC);
    chk("stall C rob", 32'(exe_rob_id), 32'd3);
    tick(); chk_nop("stall D never issued");

    // rollback with busy entries, an op on exe_* and a colliding issue
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_issue(6'd4, 32'(i), 32'd0, 1'b1, 1'b0, 4'd7, 4'd0, 32'd0, 32'd0, 4'(i));
      tick();
    end
    drive_issue(6'd5, 32'h77, 32'h88, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h200, 4'd5);
    tick(); clear_inputs();
    tick();
    chk("rb pre inst", 32'(exe_inst_name), 32'd5);
    rollback = 1'b1;
    drive_issue(6'd6, 32'h1, 32'h2, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h300, 4'd12);
    alu_bcast(4'd7, 32'h1);
    tick(); clear_inputs();
    chk("rb full", 32'(full), 32'd0);
    chk_nop("rb exe");
    chk("rb V1", exe_V1, 32'd0);
    chk("rb rob", 32'(exe_rob_id), 32'd0);
    alu_bcast(4'd7, 32'h2);
    for (int k = 0; k < 6; k++) begin
      tick();
      clear_inputs();
      chk_nop($sformatf("rb after%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
